// File: rtl/parking_lane_arbiter.sv
// Purpose: shares one gate controller between lanes A/B (round-robin), tracks lot occupancy, times blocked-gate lockouts.
// Latency: grant and ctl_rst are registered (1 cycle after the sampled event); ctl_* lane muxing is combinational.
// Backpressure: none; requests are level-held, ignored while serving/locked out or while the lot is full.
// Optional: define PARKING_ARB_STATS_EN to add admit_cnt / lockout_cnt statistics outputs.
module parking_lane_arbiter #(
    parameter int CAPACITY       = 8,
    parameter int CNT_W          = 4,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [15:0]      code_a,
    input  logic [15:0]      code_b,
    input  logic             code_ack_a,
    input  logic             code_ack_b,
    input  logic             left_a,
    input  logic             left_b,
    input  logic             exit_pulse,
    output logic             grant_a,
    output logic             grant_b,
    output logic             ctl_rst,
    output logic             ctl_vehicle_arrival,
    output logic [15:0]      ctl_code,
    output logic             ctl_code_ack,
    output logic             ctl_vehicle_left,
    input  logic             ctl_open_gate,
    input  logic             ctl_close_gate,
    input  logic             ctl_blocked_gate,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full,
    output logic             lockout
`ifdef PARKING_ARB_STATS_EN
    ,
    output logic [7:0]       admit_cnt,
    output logic [7:0]       lockout_cnt
`endif
);

    localparam int LCW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_RELEASE,
        S_ABORT,
        S_LOCKOUT
    } state_t;

    state_t         state, state_nxt;
    logic           owner, owner_nxt;          // 0 = lane A, 1 = lane B
    logic           last_grant, last_nxt;
    logic           admitted, admitted_nxt;
    logic           ctl_rst_nxt;
    logic           inc_req;
    logic           lock_enter;
    logic [LCW-1:0] lock_cnt;

    logic           own_req;
    logic [15:0]    own_code;
    logic           own_ack;
    logic           own_left;
    logic           serving;
    logic           lock_term;
    logic           occ_at_cap;

    // Owner-lane selection of the lane-side signals; the other lane never reaches the controller.
    always_comb begin
        own_req  = owner ? req_b      : req_a;
        own_code = owner ? code_b     : code_a;
        own_ack  = owner ? code_ack_b : code_ack_a;
        own_left = owner ? left_b     : left_a;
    end

    assign serving    = (state == S_SERVE);
    assign lock_term  = (lock_cnt == LCW'(LOCKOUT_CYCLES - 1));
    assign occ_at_cap = (occupancy == CNT_W'(CAPACITY));
    assign lot_full   = occ_at_cap;

    assign ctl_vehicle_arrival = serving & own_req;
    assign ctl_code            = serving ? own_code : 16'h0000;
    assign ctl_code_ack        = serving & own_ack;
    assign ctl_vehicle_left    = serving & own_left;

    // Next-state, ownership and side-effect decode; SERVE checks follow controller priority.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_nxt     = last_grant;
        admitted_nxt = admitted;
        ctl_rst_nxt  = 1'b0;
        inc_req      = 1'b0;
        lock_enter   = 1'b0;
        case (state)
            S_IDLE: begin
                admitted_nxt = 1'b0;
                if (!lot_full && (req_a || req_b)) begin
                    state_nxt = S_SERVE;
                    owner_nxt = (req_a && req_b) ? ~last_grant : req_b;
                end
            end
            S_SERVE: begin
                if (ctl_blocked_gate) begin
                    state_nxt  = S_LOCKOUT;
                    lock_enter = 1'b1;
                end else if (ctl_close_gate) begin
                    inc_req   = admitted;
                    state_nxt = S_RELEASE;
                end else if (ctl_open_gate) begin
                    admitted_nxt = 1'b1;
                end else if (!own_req && !admitted) begin
                    state_nxt   = S_ABORT;
                    ctl_rst_nxt = 1'b1;
                end
            end
            S_RELEASE, S_ABORT: begin
                admitted_nxt = 1'b0;
                last_nxt     = owner;
                state_nxt    = S_IDLE;
            end
            S_LOCKOUT: begin
                admitted_nxt = 1'b0;
                if (lock_term) begin
                    last_nxt    = owner;
                    state_nxt   = S_IDLE;
                    ctl_rst_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, ownership and registered grant/lockout/ctl_rst outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            admitted   <= 1'b0;
            grant_a    <= 1'b0;
            grant_b    <= 1'b0;
            lockout    <= 1'b0;
            ctl_rst    <= 1'b1;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_nxt;
            admitted   <= admitted_nxt;
            grant_a    <= (state_nxt == S_SERVE || state_nxt == S_LOCKOUT) && !owner_nxt;
            grant_b    <= (state_nxt == S_SERVE || state_nxt == S_LOCKOUT) &&  owner_nxt;
            lockout    <= (state_nxt == S_LOCKOUT);
            ctl_rst    <= ctl_rst_nxt;
        end
    end

    // Lockout timer: counts only while in LOCKOUT, idles at zero otherwise.
    always_ff @(posedge clk) begin
        if (rst || state != S_LOCKOUT) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt + LCW'(1);
        end
    end

    // Occupancy: a simultaneous admit and exit cancel; saturate at capacity, floor at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
        end else if (inc_req && exit_pulse) begin
            occupancy <= occupancy;
        end else if (inc_req) begin
            if (!occ_at_cap) begin
                occupancy <= occupancy + CNT_W'(1);
            end
        end else if (exit_pulse && occupancy != '0) begin
            occupancy <= occupancy - CNT_W'(1);
        end
    end

`ifdef PARKING_ARB_STATS_EN
    // Saturating statistics: real occupancy increments and entries into LOCKOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            admit_cnt   <= 8'd0;
            lockout_cnt <= 8'd0;
        end else begin
            if (inc_req && !exit_pulse && !occ_at_cap && admit_cnt != 8'hFF) begin
                admit_cnt <= admit_cnt + 8'd1;
            end
            if (lock_enter && lockout_cnt != 8'hFF) begin
                lockout_cnt <= lockout_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// Purpose: self-checking bench for parking_lane_arbiter; directed scenarios plus randomized traffic.
// Latency: compares every cycle at negedge+1 against a behavioural lot/lane model.
// Backpressure: n/a; the bench plays both lanes and the gate controller.
module tb_parking_lane_arbiter;

    localparam int CAP  = 8;
    localparam int LOCK = 16;

    localparam int PH_IDLE  = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_REL   = 2;
    localparam int PH_ABORT = 3;
    localparam int PH_LOCK  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b;
    logic [15:0] code_a, code_b;
    logic        code_ack_a, code_ack_b;
    logic        left_a, left_b;
    logic        exit_pulse;
    logic        grant_a, grant_b;
    logic        ctl_rst;
    logic        ctl_vehicle_arrival;
    logic [15:0] ctl_code;
    logic        ctl_code_ack;
    logic        ctl_vehicle_left;
    logic        ctl_open_gate, ctl_close_gate, ctl_blocked_gate;
    logic [3:0]  occupancy;
    logic        lot_full;
    logic        lockout;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model: who holds the gate, what phase the visit is in, and the lot count.
    int m_ph, m_owner, m_last, m_adm, m_occ, m_lcnt;
    bit m_ctlrst;

    always #5 clk = ~clk;

    parking_lane_arbiter #(.CAPACITY(CAP), .CNT_W(4), .LOCKOUT_CYCLES(LOCK)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b),
        .code_a(code_a), .code_b(code_b),
        .code_ack_a(code_ack_a), .code_ack_b(code_ack_b),
        .left_a(left_a), .left_b(left_b),
        .exit_pulse(exit_pulse),
        .grant_a(grant_a), .grant_b(grant_b),
        .ctl_rst(ctl_rst),
        .ctl_vehicle_arrival(ctl_vehicle_arrival),
        .ctl_code(ctl_code), .ctl_code_ack(ctl_code_ack),
        .ctl_vehicle_left(ctl_vehicle_left),
        .ctl_open_gate(ctl_open_gate), .ctl_close_gate(ctl_close_gate),
        .ctl_blocked_gate(ctl_blocked_gate),
        .occupancy(occupancy), .lot_full(lot_full), .lockout(lockout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ph = PH_IDLE; m_owner = 0; m_last = 1; m_adm = 0;
        m_occ = 0; m_lcnt = 0; m_ctlrst = 1'b1;
    endtask

    task automatic compare_outputs();
        bit srv, held;
        logic [15:0] e_code;
        srv  = (m_ph == PH_SERVE);
        held = srv || (m_ph == PH_LOCK);
        e_code = srv ? ((m_owner == 0) ? code_a : code_b) : 16'h0000;
        chk("grant_a", grant_a, held && m_owner == 0);
        chk("grant_b", grant_b, held && m_owner == 1);
        chk("lockout", lockout, m_ph == PH_LOCK);
        chk("ctl_rst", ctl_rst, m_ctlrst);
        chk("occupancy", occupancy, m_occ);
        chk("lot_full", lot_full, m_occ == CAP);
        chk("ctl_arrival", ctl_vehicle_arrival, srv && ((m_owner == 0) ? req_a : req_b));
        chk("ctl_code", ctl_code, e_code);
        chk("ctl_code_ack", ctl_code_ack, srv && ((m_owner == 0) ? code_ack_a : code_ack_b));
        chk("ctl_left", ctl_vehicle_left, srv && ((m_owner == 0) ? left_a : left_b));
    endtask

    task automatic model_step();
        bit inc, nrst, own_req;
        if (rst) begin
            model_reset();
        end else begin
            inc = 0; nrst = 0;
            own_req = (m_owner == 0) ? req_a : req_b;
            case (m_ph)
                PH_IDLE: if (m_occ < CAP && (req_a || req_b)) begin
                    if (req_a && req_b) m_owner = 1 - m_last;
                    else                m_owner = req_a ? 0 : 1;
                    m_adm = 0;
                    m_ph  = PH_SERVE;
                end
                PH_SERVE: begin
                    if (ctl_blocked_gate) begin
                        m_ph = PH_LOCK; m_lcnt = 0;
                    end else if (ctl_close_gate) begin
                        inc = (m_adm != 0); m_ph = PH_REL;
                    end else if (ctl_open_gate) begin
                        m_adm = 1;
                    end else if (!own_req && m_adm == 0) begin
                        m_ph = PH_ABORT; nrst = 1;
                    end
                end
                PH_REL, PH_ABORT: begin
                    m_last = m_owner; m_adm = 0; m_ph = PH_IDLE;
                end
                PH_LOCK: begin
                    if (m_lcnt == LOCK - 1) begin
                        m_last = m_owner; m_ph = PH_IDLE; nrst = 1;
                    end else begin
                        m_lcnt++;
                    end
                end
                default: m_ph = PH_IDLE;
            endcase
            if (inc && exit_pulse)      m_occ = m_occ;
            else if (inc)               m_occ = (m_occ < CAP) ? m_occ + 1 : CAP;
            else if (exit_pulse && m_occ > 0) m_occ = m_occ - 1;
            m_ctlrst = nrst;
        end
    endtask

    // One clock: check outputs against the model, advance the model, move to the next negedge.
    task automatic tick();
        #1;
        compare_outputs();
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_a = 0; req_b = 0; code_a = 16'h0; code_b = 16'h0;
        code_ack_a = 0; code_ack_b = 0; left_a = 0; left_b = 0;
        exit_pulse = 0; ctl_open_gate = 0; ctl_close_gate = 0; ctl_blocked_gate = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_occupancy", occupancy, 0);
        chk("rst_grant_a", grant_a, 0);
        chk("rst_ctl_rst", ctl_rst, 1);
        rst = 1'b0;
    endtask

    // Controller opens then closes; leaves the arbiter back in IDLE after RELEASE.
    task automatic admit();
        ctl_open_gate = 1; tick();
        ctl_open_gate = 0; ctl_close_gate = 1; tick();
        ctl_close_gate = 0; tick();
    endtask

    initial begin
        int n;
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        do_reset();
        tick();
        chk("post_rst_ctl_rst", ctl_rst, 0);
        chk("post_rst_lockout", lockout, 0);

        // Single lane A admission with PIN forwarded.
        req_a = 1; code_a = 16'h1234; code_ack_a = 1; code_b = 16'hBEEF;
        tick();
        chk("s1_grant_a", grant_a, 1);
        chk("s1_ctl_code", ctl_code, 16'h1234);
        ctl_open_gate = 1; tick();
        ctl_open_gate = 0; ctl_close_gate = 1; tick();
        ctl_close_gate = 0;
        chk("s1_occ", occupancy, 1);
        chk("s1_grant_release", grant_a, 0);
        req_a = 0; code_ack_a = 0; tick();
        chk("s1_idle_grant", grant_a, 0);

        // Round-robin between simultaneous requests.
        do_reset();
        req_a = 1; req_b = 1; tick();
        chk("s2_first_a", grant_a, 1);
        chk("s2_first_not_b", grant_b, 0);
        ctl_open_gate = 1; tick();
        ctl_open_gate = 0; ctl_close_gate = 1; tick();
        ctl_close_gate = 0; req_a = 0; tick();
        tick();
        chk("s2_then_b", grant_b, 1);
        admit();
        req_a = 1; tick();
        chk("s2_a_again", grant_a, 1);
        admit();
        req_a = 0; req_b = 0; tick();
        chk("s2_occ", occupancy, 3);

        // Admission and exit in the same cycle, then exit at zero.
        req_a = 1; tick();
        ctl_open_gate = 1; tick();
        ctl_open_gate = 0; ctl_close_gate = 1; exit_pulse = 1; tick();
        ctl_close_gate = 0; exit_pulse = 0;
        chk("s6_same_cycle_occ", occupancy, 3);
        req_a = 0; tick();
        exit_pulse = 1;
        repeat (3) tick();
        chk("s6_drained", occupancy, 0);
        tick();
        chk("s6_exit_at_zero", occupancy, 0);
        exit_pulse = 0;

        // Fill the lot, then a waiting lane is granted only after an exit.
        for (int i = 0; i < CAP; i++) begin
            req_a = 1; tick();
            admit();
        end
        req_a = 0;
        chk("s3_full_occ", occupancy, 8);
        chk("s3_lot_full", lot_full, 1);
        req_b = 1; tick(); tick();
        chk("s3_no_grant_full", grant_b, 0);
        exit_pulse = 1; tick();
        exit_pulse = 0;
        chk("s3_after_exit", occupancy, 7);
        tick();
        chk("s3_grant_b", grant_b, 1);

        // Blocked gate: 16-cycle lockout, ctl_rst pulse, other lane first.
        req_a = 1;
        ctl_blocked_gate = 1; tick();
        ctl_blocked_gate = 0;
        chk("s4_lockout_on", lockout, 1);
        n = 0;
        while (lockout === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("s4_lock_len", n, LOCK);
        chk("s4_ctl_rst", ctl_rst, 1);
        chk("s4_occ_kept", occupancy, 7);
        chk("s4_grant_dropped", grant_b, 0);
        tick();
        chk("s4_other_lane", grant_a, 1);

        // Owner leaves before the gate opens.
        req_a = 0; req_b = 0; tick();
        chk("s5_abort_ctl_rst", ctl_rst, 1);
        chk("s5_abort_grant", grant_a, 0);
        chk("s5_abort_occ", occupancy, 7);
        tick();
        chk("s5_idle_ctl_rst", ctl_rst, 0);

        // Reset in the middle of a service.
        req_a = 1; tick();
        do_reset();
        req_a = 0;

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) req_a = ~req_a;
            if ($urandom_range(0, 7) == 0) req_b = ~req_b;
            code_a           = 16'($urandom);
            code_b           = 16'($urandom);
            code_ack_a       = ($urandom_range(0, 3) == 0);
            code_ack_b       = ($urandom_range(0, 3) == 0);
            left_a           = ($urandom_range(0, 5) == 0);
            left_b           = ($urandom_range(0, 5) == 0);
            ctl_open_gate    = ($urandom_range(0, 5) == 0);
            ctl_close_gate   = ($urandom_range(0, 7) == 0);
            ctl_blocked_gate = ($urandom_range(0, 59) == 0);
            exit_pulse       = ($urandom_range(0, 9) == 0);
            rst              = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0;
        clear_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
